// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a 2-cycle BRAM with a PC-tagged output FIFO.
module fetch_ctrl #(
  parameter int PC_WIDTH = 16,
  parameter int INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt_i,
  input  logic                  redirect_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  output logic [PC_WIDTH-1:0]   bram_addr_o,
  output logic                  bram_en_o,
  input  logic [INST_WIDTH-1:0] bram_dout_i,
  output logic                  inst_valid_o,
  output logic [PC_WIDTH-1:0]   inst_pc_o,
  output logic [INST_WIDTH-1:0] inst_o,
  input  logic                  inst_ready_i,
  output logic                  busy_o
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 3);
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc1_q, pc2_q;
  logic v1_q, v2_q;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [CW-1:0] cnt;
  logic push, pop;
  logic [PC_WIDTH-1:0] fpc_q [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] finst_q [FIFO_DEPTH];
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  // Credits cover every word in flight or buffered, so the FIFO can never overflow.
  assign cnt = CW'(v1_q) + CW'(v2_q) + CW'(occ_q);
  assign bram_en_o = rst_n & ~redirect_i & ~halt_i & (cnt < CW'(FIFO_DEPTH));
  assign bram_addr_o = pc_q;
  assign inst_valid_o = occ_q != '0;
  assign inst_pc_o = inst_valid_o ? fpc_q[rd_q] : '0;
  assign inst_o = inst_valid_o ? finst_q[rd_q] : '0;
  assign busy_o = v1_q | v2_q | inst_valid_o;
  assign push = v2_q & ~redirect_i;
  assign pop = inst_valid_o & inst_ready_i & ~redirect_i;
  always_comb begin
    pc_d = redirect_i ? redirect_pc_i : bram_en_o ? pc_q + PC_WIDTH'(PC_STEP) : pc_q;
    wr_d = redirect_i ? '0 : push ? nxt(wr_q) : wr_q;
    rd_d = redirect_i ? '0 : pop ? nxt(rd_q) : rd_q;
    occ_d = redirect_i ? '0 : occ_q + OW'(push) - OW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      pc1_q <= '0;
      pc2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
    end else begin
      pc_q <= pc_d;
      pc1_q <= pc_q;
      pc2_q <= pc1_q;
      v1_q <= bram_en_o;
      v2_q <= v1_q & ~redirect_i;
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fpc_q[wr_q] <= pc2_q;
      finst_q[wr_q] <= bram_dout_i;
    end
  end
endmodule
